// File: rtl/bcd_serial_accumulator.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first,
// with the decimal carry held in a flop between digits.
module bcd_serial_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, inv_q, inv_d;

  logic [3:0] a_dig, b_dig;
  logic [4:0] dig_res;

  // Returns {carry, digit}; out-of-range nibbles go through the same rule.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0, c};
    if (s > 5'd9) begin
      s = s + 5'd6;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    dig_res = bcd_digit_add(a_dig, b_dig, carry_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          inv_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig_res[3:0];
        end
        carry_d = dig_res[4];
        inv_d   = inv_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        if (idx_q == LAST) begin
          cout_d  = dig_res[4];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
    end
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Bench for bcd_serial_accumulator: vector table, corner sequences and
// randomized operations checked against a decimal reference model.
module tb_bcd_serial_accumulator;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_serial_accumulator #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
    logic         ei;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit all_valid(input logic [W-1:0] x);
    for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] x);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  // Reference: plain decimal addition for legal operands; digit rule otherwise.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] r = '0;
    int lim = 1;
    int t, s, cy;
    for (int i = 0; i < D; i++) lim = lim * 10;
    if (all_valid(x) && all_valid(y)) begin
      t = bcd2int(x) + bcd2int(y) + int'(c);
      cy = (t >= lim) ? 1 : 0;
      t = t % lim;
      for (int i = 0; i < D; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end else begin
      cy = int'(c);
      for (int i = 0; i < D; i++) begin
        s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cy;
        if (s > 9) begin
          r[4*i +: 4] = 4'((s + 6) % 16);
          cy = 1;
        end else begin
          r[4*i +: 4] = 4'(s);
          cy = 0;
        end
      end
    end
    return {cy[0], r};
  endfunction

  // Issues one start pulse, scrambles inputs while busy, checks timing and result.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec, input logic ei);
    int lat, bcnt;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, D + 1);
    chk({tag, " busy_cycles"}, bcnt, D);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " invalid"}, invalid, ei);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 1'b0);
    chk({tag, " sum_held"}, sum, es);
  endtask

  vec_t vecs[$];
  logic [W:0] m;

  initial begin
    vecs.push_back('{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0});
    vecs.push_back('{16'h00F0, 16'h00F0, 1'b0, 16'h0140, 1'b0, 1'b1});
    vecs.push_back('{16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0});
    vecs.push_back('{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hA000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1});

    // Reset state while rst_n is low
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum, '0);
    chk("rst cout", cout, 1'b0);
    chk("rst invalid", invalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc,
             vecs[i].es, vecs[i].ec, vecs[i].ei);

    // Ignored start during ADD: result and done belong to the first operation
    begin
      int dcnt = 0;
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      a = 16'h4444; b = 16'h3333; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (done) begin
          dcnt++;
          chk("ignstart sum", sum, 16'h6912);
          chk("ignstart cout", cout, 1'b0);
        end
        @(negedge clk);
      end
      chk("ignstart done_count", dcnt, 1);
    end

    // Asynchronous reset during the second ADD cycle
    begin
      int dcnt = 0;
      @(negedge clk);
      a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", busy, 1'b0);
      chk("midrst sum", sum, '0);
      chk("midrst cout", cout, 1'b0);
      chk("midrst invalid", invalid, 1'b0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) dcnt++;
        if (k == 2) rst_n = 1'b1;
      end
      chk("midrst done_count", dcnt, 0);
      run_op("postrst", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    end

    // Randomized operations, occasionally with out-of-range nibbles
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      rc = 1'($urandom);
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      m = model(ra, rb, rc);
      run_op($sformatf("rand%0d", r), ra, rb, rc, m[W-1:0], m[W],
             !(all_valid(ra) && all_valid(rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
